// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment display-bus reader: segment patterns (a..g, active low)
// and the decode result carried from the pattern decoder to the capture registers.
package sevseg_pkg;

    localparam int CODE_W = 4;

    // Index 0 is segment a, index 6 is segment g; a 0 bit means the segment is lit.
    typedef logic [0:6] seg_t;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0001100;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b1100000;
    localparam seg_t SEG_C     = 7'b0110001;
    localparam seg_t SEG_D     = 7'b1000010;
    localparam seg_t SEG_E     = 7'b0110000;
    localparam seg_t SEG_F     = 7'b0111000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              blank;
        logic              err;
    } dec_t;

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// Combinational segment-pattern to digit-code decoder (inverse of the BCD-to-segment encoder).
// Define SEVSEG_HEX_EN to also accept the hex letter patterns A..F as codes 10..15.
module seven_seg_pattern_decode
    import sevseg_pkg::*;
(
    input  seg_t pattern,
    output dec_t result
);

    always_comb begin
        result = '0;
        case (pattern)
            SEG_0:     result.code = 4'd0;
            SEG_1:     result.code = 4'd1;
            SEG_2:     result.code = 4'd2;
            SEG_3:     result.code = 4'd3;
            SEG_4:     result.code = 4'd4;
            SEG_5:     result.code = 4'd5;
            SEG_6:     result.code = 4'd6;
            SEG_7:     result.code = 4'd7;
            SEG_8:     result.code = 4'd8;
            SEG_9:     result.code = 4'd9;
            SEG_BLANK: result.blank = 1'b1;
`ifdef SEVSEG_HEX_EN
            SEG_A:     result.code = 4'd10;
            SEG_B:     result.code = 4'd11;
            SEG_C:     result.code = 4'd12;
            SEG_D:     result.code = 4'd13;
            SEG_E:     result.code = 4'd14;
            SEG_F:     result.code = 4'd15;
`endif
            default:   result.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Monitors a multiplexed active-low seven-segment bus, qualifies each digit by stability and
// hands complete frames of NDIG digit codes to a consumer. Hex letters decode when SEVSEG_HEX_EN is defined.
module seven_seg_reader
    import sevseg_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [0:6]               seg_n,
    input  logic [NDIG-1:0]          an_n,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [CODE_W*NDIG-1:0]   out_digits,
    output logic [NDIG-1:0]          out_blank,
    output logic [NDIG-1:0]          out_err,
    output logic                     overrun
);

    // Run counter saturates one past the capture point so each stable run captures exactly once.
    localparam int RUN_MAX = STABLE_CYC + 1;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    seg_t                   s_seg;
    logic [NDIG-1:0]        s_an;
    logic [RUN_W-1:0]       run;
    logic [NDIG-1:0]        sel_n;
    logic                   sel_ok;
    logic                   sample_same;
    logic                   capture;
    logic [NDIG-1:0]        cap_sel;
    logic [CODE_W*NDIG-1:0] cap_digits;
    logic [NDIG-1:0]        cap_blank;
    logic [NDIG-1:0]        cap_err;
    logic [NDIG-1:0]        mask;
    logic                   mask_full;
    dec_t                   dec;

    seven_seg_pattern_decode u_decode (
        .pattern (s_seg),
        .result  (dec)
    );

    // A select is valid only when exactly one anode is driven low.
    always_comb begin
        sel_n       = ~an_n;
        sel_ok      = (sel_n != '0) && ((sel_n & (sel_n - 1'b1)) == '0);
        sample_same = (seg_n == s_seg) && (an_n == s_an);
        capture     = (run == RUN_W'(STABLE_CYC));
        cap_sel     = capture ? ~s_an : '0;
        mask_full   = &mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg <= '1;
            s_an  <= '1;
            run   <= '0;
        end else begin
            s_seg <= seg_n;
            s_an  <= an_n;
            if (!sample_same)
                run <= sel_ok ? RUN_W'(1) : '0;
            else if (!sel_ok)
                run <= '0;
            else if (run != RUN_W'(RUN_MAX))
                run <= run + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_digits <= '0;
            cap_blank  <= '0;
            cap_err    <= '0;
            mask       <= '0;
        end else begin
            for (int k = 0; k < NDIG; k++) begin
                if (cap_sel[k]) begin
                    cap_digits[k*CODE_W +: CODE_W] <= dec.code;
                    cap_blank[k]                   <= dec.blank;
                    cap_err[k]                     <= dec.err;
                end
            end
            mask <= (mask_full ? '0 : mask) | cap_sel;
        end
    end

    // Handshake: out_valid stays high with out_digits/out_blank/out_err stable until a cycle where
    // out_valid && out_ready; out_valid then falls on the next edge unless a new frame loads on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_digits <= '0;
            out_blank  <= '0;
            out_err    <= '0;
            overrun    <= 1'b0;
        end else if (mask_full) begin
            out_valid  <= 1'b1;
            out_digits <= cap_digits;
            out_blank  <= cap_blank;
            out_err    <= cap_err;
            if (out_valid && !out_ready)
                overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed and randomized bench for seven_seg_reader with a frame-level reference model.
module tb_seven_seg_reader;

    localparam int NDIG = 4;
    localparam int S    = 3;
    localparam int W    = 6 * NDIG;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [0:6]         seg_n;
    logic [NDIG-1:0]    an_n;
    logic               out_ready;
    logic               out_valid;
    logic [4*NDIG-1:0]  out_digits;
    logic [NDIG-1:0]    out_blank;
    logic [NDIG-1:0]    out_err;
    logic               overrun;

    int n_assert = 0;
    int n_fail   = 0;
    logic mon_en = 1'b1;

    logic [W-1:0] exp_q[$];

    logic [0:6] seg_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
        7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // model state: digits captured so far in the current frame
    logic [4*NDIG-1:0] m_dig;
    logic [NDIG-1:0]   m_blank, m_err, m_mask;
    logic [0:6]        prev_p;
    logic [NDIG-1:0]   prev_a;

    seven_seg_reader #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_digits (out_digits),
        .out_blank  (out_blank),
        .out_err    (out_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // {code[3:0], blank, err}
    function automatic logic [5:0] ref_decode(input logic [0:6] p);
        int top_d;
`ifdef SEVSEG_HEX_EN
        top_d = 15;
`else
        top_d = 9;
`endif
        if (p == 7'b1111111) return 6'b0000_10;
        for (int d = 0; d <= top_d; d++)
            if (p == seg_tbl[d]) return {d[3:0], 2'b00};
        return 6'b0000_01;
    endfunction

    function automatic logic [NDIG-1:0] sel(input int k);
        return {NDIG{1'b1}} ^ (NDIG'(1) << k);
    endfunction

    task automatic model_reset();
        m_dig = '0; m_blank = '0; m_err = '0; m_mask = '0;
    endtask

    // A hold is accepted when exactly one anode is low and it lasts at least S edges.
    task automatic model_hold(input logic [0:6] p, input logic [NDIG-1:0] a, input int n);
        logic [5:0] r;
        int idx;
        idx = 0;
        if ($countones(~a) == 1 && n >= S) begin
            for (int k = 0; k < NDIG; k++) if (!a[k]) idx = k;
            r = ref_decode(p);
            m_dig[idx*4 +: 4] = r[5:2];
            m_blank[idx]      = r[1];
            m_err[idx]        = r[0];
            m_mask[idx]       = 1'b1;
            if (&m_mask) begin
                exp_q.push_back({m_err, m_blank, m_dig});
                m_mask = '0;
            end
        end
    endtask

    task automatic drive(input logic [0:6] p, input logic [NDIG-1:0] a, input int n);
        seg_n = p;
        an_n  = a;
        prev_p = p;
        prev_a = a;
        model_hold(p, a, n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        drive(7'b1111111, '1, n);
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("wait_valid_timeout", 64'(cnt < 40), 64'd1);
    endtask

    // Present the final digit of a frame and count edges until out_valid rises.
    task automatic last_digit(input int k, input logic [0:6] p, output int cnt);
        seg_n = p;
        an_n  = sel(k);
        prev_p = p;
        prev_a = sel(k);
        model_hold(p, sel(k), S + 1);
        wait_valid(cnt);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n && out_valid && out_ready) begin
            check("frame_queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
                check("frame", 64'({out_err, out_blank, out_digits}), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        int cnt;
        int s;
        logic [0:6] p;
        logic [NDIG-1:0] a;

        rst_n = 1'b0;
        seg_n = 7'b1111111;
        an_n = '1;
        out_ready = 1'b1;
        prev_p = 7'b1111111;
        prev_a = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_digits", 64'(out_digits), 64'd0);
        check("rst_blank", 64'(out_blank), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // basic scan 1,2,3,4 and last-digit latency
        drive(seg_tbl[1], sel(0), 4);
        drive(seg_tbl[2], sel(1), 4);
        drive(seg_tbl[3], sel(2), 4);
        last_digit(3, seg_tbl[4], cnt);
        check("latency", 64'(cnt), 64'(S + 2));
        check("scan_digits", 64'(out_digits), 64'h4321);
        check("scan_blank", 64'(out_blank), 64'd0);
        check("scan_err", 64'(out_err), 64'd0);
        idle(3);

        // digit 2 held too briefly
        drive(seg_tbl[1], sel(0), 4);
        drive(seg_tbl[2], sel(1), 4);
        drive(seg_tbl[3], sel(2), S - 1);
        drive(seg_tbl[4], sel(3), 4);
        idle(6);
        check("short_no_valid", 64'(out_valid), 64'd0);
        last_digit(2, seg_tbl[3], cnt);
        check("short_repeat_latency", 64'(cnt), 64'(S + 2));
        check("short_repeat_digits", 64'(out_digits), 64'h4321);
        idle(3);

        // two anodes low
        drive(seg_tbl[5], 4'b1100, 10);
        idle(3);
        check("dual_sel_no_valid", 64'(out_valid), 64'd0);
        drive(seg_tbl[6], sel(0), 4);
        drive(seg_tbl[7], sel(1), 4);
        drive(seg_tbl[8], sel(2), 4);
        last_digit(3, seg_tbl[9], cnt);
        check("dual_sel_digits", 64'(out_digits), 64'h9876);
        idle(3);

        // overrun with consumer stalled
        mon_en = 1'b0;
        out_ready = 1'b0;
        drive(seg_tbl[5], sel(0), 4);
        drive(seg_tbl[6], sel(1), 4);
        drive(seg_tbl[7], sel(2), 4);
        drive(seg_tbl[8], sel(3), 4);
        idle(3);
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_no_overrun", 64'(overrun), 64'd0);
        check("stall_first_digits", 64'(out_digits), 64'h8765);
        drive(seg_tbl[9], sel(0), 4);
        drive(seg_tbl[0], sel(1), 4);
        drive(seg_tbl[1], sel(2), 4);
        drive(seg_tbl[2], sel(3), 4);
        idle(3);
        check("overrun_set", 64'(overrun), 64'd1);
        check("overrun_valid", 64'(out_valid), 64'd1);
        check("overrun_digits", 64'(out_digits), 64'h2109);
        check("overrun_model", 64'(out_digits), 64'(exp_q[exp_q.size()-1][4*NDIG-1:0]));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("accept_drop", 64'(out_valid), 64'd0);
        check("overrun_sticky", 64'(overrun), 64'd1);
        exp_q.delete();
        mon_en = 1'b1;
        idle(2);

        // hex letter on digit 1, blank on digit 2
        drive(seg_tbl[8], sel(0), 4);
        drive(7'b0001000, sel(1), 4);
        drive(7'b1111111, sel(2), 4);
        last_digit(3, seg_tbl[7], cnt);
`ifdef SEVSEG_HEX_EN
        check("hex_code", 64'(out_digits[7:4]), 64'hA);
        check("hex_err", 64'(out_err), 64'd0);
`else
        check("hex_code", 64'(out_digits[7:4]), 64'h0);
        check("hex_err", 64'(out_err), 64'b0010);
`endif
        check("blank_flag", 64'(out_blank), 64'b0100);
        idle(3);

        // reset with a partial frame
        drive(seg_tbl[3], sel(0), S + 1);
        drive(seg_tbl[4], sel(1), S + 1);
        seg_n = 7'b1111111;
        an_n = '1;
        prev_p = seg_n;
        prev_a = an_n;
        rst_n = 1'b0;
        #2;
        check("mid_rst_digits", 64'(out_digits), 64'd0);
        check("mid_rst_overrun", 64'(overrun), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(2);
        drive(seg_tbl[5], sel(2), S + 1);
        drive(seg_tbl[6], sel(3), S + 1);
        idle(6);
        check("post_rst_partial", 64'(out_valid), 64'd0);
        drive(seg_tbl[1], sel(0), S + 1);
        last_digit(1, seg_tbl[2], cnt);
        check("post_rst_digits", 64'(out_digits), 64'h6521);
        idle(3);

        // randomized scans
        for (int i = 0; i < 80; i++) begin
            do begin
                s = $urandom_range(0, 9);
                if (s < 7) p = seg_tbl[$urandom_range(0, 9)];
                else if (s == 7) p = 7'b1111111;
                else p = 7'($urandom_range(0, 127));
                a = (s == 9) ? NDIG'($urandom_range(0, 15)) : sel($urandom_range(0, NDIG - 1));
            end while (p == prev_p && a == prev_a);
            drive(p, a, $urandom_range(1, 6));
        end
        idle(10);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
